class_hvec_mem: RTL and testbench
=================================

Name: class_hvec_mem

Overview:
- Parametrised, writable successor to the fixed class-vector ROM. Stores N_CLASSES class hypervectors, each split into N_FRAMES frames of FRAME_W bits.
- A command port selects READ, WRITE or CLEAR per class. Frames stream out or in over valid/ready handshakes.
- Sits between the training/loader path (writer) and the associative-search comparator (reader).

Parameters:
FRAME_W, 64, bits per frame
N_FRAMES, 3, frames per class hypervector (>=1)
N_CLASSES, 8, number of class slots (>=1, need not be a power of 2)
CLS_W, max(1,$clog2(N_CLASSES)), class-id width (derived, localparam)
FRM_W, max(1,$clog2(N_FRAMES)), frame-index width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  2  0=READ, 1=WRITE, 2=CLEAR, 3=NOP
cmd_class  in  CLS_W  target class id
cmd_err  out  1  one-cycle pulse: accepted command had cmd_class>=N_CLASSES
wr_valid  in  1  write frame valid
wr_ready  out  1  write frame accepted when wr_valid&&wr_ready
wr_data  in  FRAME_W  write frame payload
rd_valid  out  1  read frame valid
rd_ready  in  1  downstream accepts read frame
rd_data  out  FRAME_W  read frame payload
rd_frame  out  FRM_W  index of current read frame
rd_last  out  1  current read frame is frame N_FRAMES-1
rd_empty  out  1  class read is unprogrammed; rd_data forced 0
busy  out  1  state != IDLE
class_vld  out  N_CLASSES  per-class programmed flag

Behaviour:
- Reset (async assert, sync release): state=IDLE. class_vld=0. All outputs 0 except cmd_ready=1. Storage array is not reset.
- Reset mid-operation aborts the transfer. A partially written class stays invalid.
- FSM states: IDLE, RD, WR. cmd_ready = (state==IDLE). wr_ready = (state==WR). rd_valid = (state==RD).
- Accept in IDLE with cmd_class>=N_CLASSES, any op:
  - cmd_err=1 next cycle.
  - No state or storage change; stay IDLE.
- NOP: accepted, no effect, stay IDLE.
- CLEAR:
  - class_vld[c]<=0 on the accepting edge; stay IDLE.
  - Storage is not zeroed.
- READ:
  - On the accept edge: state<=RD, idx<=0, rd_data<=frame 0 (or 0 if !class_vld[c]), rd_empty<=!class_vld[c].
  - First rd_valid one cycle after accept.
  - On each rd_valid&&rd_ready: if idx==N_FRAMES-1, state<=IDLE and rd_valid drops. Otherwise idx++ and rd_data<=next frame.
  - rd_data, rd_frame, rd_last and rd_empty stay stable while rd_valid&&!rd_ready.
  - rd_empty is constant for the whole burst.
  - Minimum READ cost is N_FRAMES+1 cycles; the next command can be accepted in the cycle after the last beat.
- WRITE:
  - On the accept edge: state<=WR, idx<=0, class_vld[c]<=0 (class invalidated during rewrite).
  - Each wr_valid&&wr_ready stores wr_data to mem[c][idx] and does idx++.
  - On beat N_FRAMES-1: class_vld[c]<=1 and state<=IDLE.
  - No timeout. Idle wr_valid holds WR indefinitely.
- cmd_valid is ignored while busy. No read and write overlap (single FSM).
- N_FRAMES=1: rd_last=1 on the only beat; WRITE completes after one beat.
- Storage: N_CLASSES*N_FRAMES words of FRAME_W bits, flop or inferred-RAM. Read path is registered.

Decomposition:
- Shared package hdc_mem_pkg holds:
  - the op encoding (OP_READ=2'd0, OP_WRITE=2'd1, OP_CLEAR=2'd2, OP_NOP=2'd3);
  - the FSM state enum;
  - a clog2_min1 function used to derive CLS_W and FRM_W.
- One sub-module, hvec_frame_ram: a single-port, synchronous-read, FRAME_W x (N_CLASSES*N_FRAMES) array with address = class*N_FRAMES+frame. It allows RAM inference for large FRAME_W.
- The FSM, handshake and class_vld logic stay in class_hvec_mem.

Test Plan:
- Reset release, then READ class 3 -> three beats with rd_frame 0,1,2, rd_data=0, rd_empty=1, rd_last on beat 2; class_vld=8'h00.
- WRITE class 5 with frames 64'hA5A5..., 64'h0F0F..., 64'hFFFF_0000_FFFF_0000, then READ 5 -> identical frames in order, rd_empty=0; class_vld=8'h20.
- READ class 5 with rd_ready toggled 1,0,0,1,0,1 -> each frame held stable while stalled; exactly 3 handshakes; cmd_ready returns the cycle after the last beat.
- CLEAR class 5, then READ 5 -> rd_empty=1 and zero data; class_vld[5]=0.
- With N_CLASSES=6: cmd_class=7, op READ -> cmd_err one-cycle pulse, busy stays 0, no rd_valid.
- WRITE class 2 with 2 of 3 beats sent, then assert rst_n=0 -> busy=0, class_vld[2]=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/hdc_mem_pkg.sv
// Shared definitions for the class hypervector memory.
// Holds the command op encoding, the controller state enum and a
// width helper that never returns zero.
package hdc_mem_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // Index width for n entries, at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/hvec_frame_ram.sv
// Single-port frame storage with synchronous read.
// Ports: clk; we/wdata write at addr; re loads rdata from addr
// (rdata holds when re is low). Contents are not reset.
module hvec_frame_ram #(
  parameter int unsigned FRAME_W = 64,
  parameter int unsigned DEPTH   = 24,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [FRAME_W-1:0] wdata,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem [DEPTH];

  // Plain RAM template so large arrays map onto memory macros.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/class_hvec_mem.sv
// Writable class hypervector store.
// Ports: cmd_* selects READ/WRITE/CLEAR/NOP per class (cmd_err flags an
// out-of-range class); wr_* streams frames in; rd_* streams frames out
// with frame index, last and empty flags; busy and class_vld report status.
module class_hvec_mem
  import hdc_mem_pkg::*;
#(
  parameter  int unsigned FRAME_W   = 64,
  parameter  int unsigned N_FRAMES  = 3,
  parameter  int unsigned N_CLASSES = 8,
  localparam int unsigned CLS_W     = clog2_min1(N_CLASSES),
  localparam int unsigned FRM_W     = clog2_min1(N_FRAMES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CLS_W-1:0]     cmd_class,
  output logic                 cmd_err,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FRAME_W-1:0]   wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [FRAME_W-1:0]   rd_data,
  output logic [FRM_W-1:0]     rd_frame,
  output logic                 rd_last,
  output logic                 rd_empty,
  output logic                 busy,
  output logic [N_CLASSES-1:0] class_vld
);

  localparam int unsigned      DEPTH    = N_CLASSES * N_FRAMES;
  localparam int unsigned      ADDR_W   = clog2_min1(DEPTH);
  localparam logic [FRM_W-1:0] LAST_IDX = FRM_W'(N_FRAMES - 1);

  state_e             state_q, state_d;
  logic [FRM_W-1:0]   idx_q;
  logic [CLS_W-1:0]   cls_q;
  logic               rd_empty_q;
  logic [FRAME_W-1:0] ram_q;

  logic               cmd_fire, cmd_bad, cmd_ok;
  logic               idx_last, rd_fire, wr_fire;
  logic               ram_re;
  logic [CLS_W-1:0]   addr_cls;
  logic [FRM_W-1:0]   addr_frm;
  logic [ADDR_W-1:0]  ram_addr;

  assign cmd_fire = cmd_valid && (state_q == ST_IDLE);
  assign cmd_bad  = 32'(cmd_class) >= N_CLASSES;
  assign cmd_ok   = cmd_fire && !cmd_bad;
  assign idx_last = (idx_q == LAST_IDX);
  assign rd_fire  = (state_q == ST_RD) && rd_ready;
  assign wr_fire  = (state_q == ST_WR) && wr_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ok && (cmd_op == OP_READ))  state_d = ST_RD;
        if (cmd_ok && (cmd_op == OP_WRITE)) state_d = ST_WR;
      end
      ST_RD:   if (rd_fire && idx_last) state_d = ST_IDLE;
      ST_WR:   if (wr_fire && idx_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; read data masked when empty.
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b1;
    rd_data   = '0;
    rd_frame  = idx_q;
    rd_last   = 1'b0;
    rd_empty  = rd_empty_q;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RD: begin
        rd_valid = 1'b1;
        rd_last  = idx_last;
        if (!rd_empty_q) rd_data = ram_q;
      end
      ST_WR:   wr_ready = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // RAM address: frame 0 of the commanded class when idle, the next frame
  // while reading (prefetch on handshake), the current frame while writing.
  always_comb begin
    addr_cls = cls_q;
    addr_frm = idx_q;
    if (state_q == ST_IDLE) begin
      addr_cls = cmd_class;
      addr_frm = '0;
    end else if (state_q == ST_RD) begin
      addr_frm = idx_q + FRM_W'(1);
    end
  end

  assign ram_addr = ADDR_W'(32'(addr_cls) * N_FRAMES + 32'(addr_frm));
  assign ram_re   = (cmd_ok && (cmd_op == OP_READ)) || (rd_fire && !idx_last);

  // Frame index, target class, empty flag and per-class valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      cls_q      <= '0;
      rd_empty_q <= 1'b0;
      class_vld  <= '0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= cmd_fire && cmd_bad;
      if (cmd_ok) begin
        unique case (cmd_op)
          OP_READ: begin
            cls_q      <= cmd_class;
            idx_q      <= '0;
            rd_empty_q <= !class_vld[cmd_class];
          end
          OP_WRITE: begin
            cls_q                <= cmd_class;
            idx_q                <= '0;
            class_vld[cmd_class] <= 1'b0;
          end
          OP_CLEAR: class_vld[cmd_class] <= 1'b0;
          default: ;
        endcase
      end
      if (rd_fire || wr_fire) begin
        idx_q <= idx_last ? '0 : idx_q + FRM_W'(1);
      end
      // Class becomes readable only once its final frame has landed.
      if (wr_fire && idx_last) class_vld[cls_q] <= 1'b1;
    end
  end

  hvec_frame_ram #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_class_hvec_mem.sv
// Self-checking bench for class_hvec_mem: an 8-class instance for the main
// flows and a 6-class instance for out-of-range class ids.
module tb_class_hvec_mem;
  import hdc_mem_pkg::*;

  localparam int NF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-class instance
  logic        cmd_valid, cmd_ready, cmd_err;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_class;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_ready, rd_last, rd_empty, busy;
  logic [63:0] rd_data;
  logic [1:0]  rd_frame;
  logic [7:0]  class_vld;

  // 6-class instance
  logic        e_cmd_valid, e_cmd_ready, e_cmd_err;
  logic [1:0]  e_cmd_op;
  logic [2:0]  e_cmd_class;
  logic        e_wr_valid, e_wr_ready;
  logic [63:0] e_wr_data;
  logic        e_rd_valid, e_rd_ready, e_rd_last, e_rd_empty, e_busy;
  logic [63:0] e_rd_data;
  logic [1:0]  e_rd_frame;
  logic [5:0]  e_class_vld;

  class_hvec_mem #(.FRAME_W(64), .N_FRAMES(3), .N_CLASSES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_class(cmd_class), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_frame(rd_frame), .rd_last(rd_last), .rd_empty(rd_empty),
    .busy(busy), .class_vld(class_vld)
  );

  class_hvec_mem #(.FRAME_W(64), .N_FRAMES(3), .N_CLASSES(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready), .cmd_op(e_cmd_op),
    .cmd_class(e_cmd_class), .cmd_err(e_cmd_err),
    .wr_valid(e_wr_valid), .wr_ready(e_wr_ready), .wr_data(e_wr_data),
    .rd_valid(e_rd_valid), .rd_ready(e_rd_ready), .rd_data(e_rd_data),
    .rd_frame(e_rd_frame), .rd_last(e_rd_last), .rd_empty(e_rd_empty),
    .busy(e_busy), .class_vld(e_class_vld)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  frame;
    logic        last;
    logic        empty;
  } beat_t;

  beat_t       sb[$];
  beat_t       held_b;
  logic        held = 1'b0;
  int          hs_count = 0;
  logic [63:0] model_mem [8][3];
  logic [7:0]  model_vld = '0;

  // Read monitor: pops the scoreboard on each handshake, checks stall hold.
  always @(negedge clk) begin : mon
    beat_t got, exp_b;
    got = '{data: rd_data, frame: rd_frame, last: rd_last, empty: rd_empty};
    if (!rst_n || !rd_valid) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_data", got.data, held_b.data);
        chk("stall_ctl", 64'({got.frame, got.last, got.empty}),
            64'({held_b.frame, held_b.last, held_b.empty}));
      end
      if (rd_ready) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 64'(rd_valid), 64'd0);
        end else begin
          exp_b = sb.pop_front();
          chk("rd_data",  got.data, exp_b.data);
          chk("rd_frame", 64'(got.frame), 64'(exp_b.frame));
          chk("rd_last",  64'(got.last),  64'(exp_b.last));
          chk("rd_empty", 64'(got.empty), 64'(exp_b.empty));
          hs_count++;
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_b = got;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] cls);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_class = cls;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
  endtask

  task automatic do_read(input logic [2:0] cls, input logic [7:0] pat, input int plen);
    int n;
    int hs0;
    for (int f = 0; f < NF; f++) begin
      beat_t b;
      b.empty = !model_vld[cls];
      b.data  = b.empty ? 64'd0 : model_mem[cls][f];
      b.frame = 2'(f);
      b.last  = (f == NF - 1);
      sb.push_back(b);
    end
    hs0 = hs_count;
    send_cmd(OP_READ, cls);
    chk("rd_busy", 64'(busy), 64'd1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      rd_ready = (n < plen) ? pat[n] : 1'b1;
      step();
      n++;
    end
    rd_ready = 1'b0;
    chk("rd_drain", 64'(sb.size()), 64'd0);
    chk("rd_hs_count", 64'(hs_count - hs0), 64'(NF));
    chk("rd_cmd_ready_back", 64'(cmd_ready), 64'd1);
    chk("rd_valid_drop", 64'(rd_valid), 64'd0);
    sb.delete();
  endtask

  task automatic do_write(input logic [2:0] cls, input logic [63:0] f0, input logic [63:0] f1,
                          input logic [63:0] f2, input int nbeats, input bit gap);
    logic [63:0] fr [3];
    fr[0] = f0;
    fr[1] = f1;
    fr[2] = f2;
    send_cmd(OP_WRITE, cls);
    model_vld[cls] = 1'b0;
    chk("wr_invalidated", 64'(class_vld[cls]), 64'd0);
    chk("wr_ready", 64'(wr_ready), 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        step();
        chk("wr_hold_busy", 64'(busy), 64'd1);
      end
      wr_valid = 1'b1;
      wr_data  = fr[i];
      step();
      model_mem[cls][i] = fr[i];
    end
    wr_valid = 1'b0;
    if (nbeats == NF) begin
      model_vld[cls] = 1'b1;
      chk("wr_done_idle", 64'(busy), 64'd0);
      chk("wr_class_vld", 64'(class_vld), 64'(model_vld));
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_class = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    e_cmd_valid = 1'b0; e_cmd_op = 2'd3; e_cmd_class = '0;
    e_wr_valid = 1'b0; e_wr_data = '0; e_rd_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_class_vld", 64'(class_vld), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    chk("rst_rd_empty", 64'(rd_empty), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;
    step();

    // Unprogrammed class reads back empty
    do_read(3'd3, 8'hFF, 0);
    chk("vld_after_empty_read", 64'(class_vld), 64'h00);

    // Write class 5 (with an idle gap) and read it back
    do_write(3'd5, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_0F0F_0F0F,
             64'hFFFF_0000_FFFF_0000, NF, 1'b1);
    chk("vld_class5", 64'(class_vld), 64'h20);
    do_read(3'd5, 8'hFF, 0);

    // Backpressured read: ready 1,0,0,1,0,1
    do_read(3'd5, 8'b0010_1001, 6);

    // Boundary classes 0 and 7 with random payloads
    do_write(3'd0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, NF, 1'b0);
    do_write(3'd7, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, NF, 1'b0);
    chk("vld_0_5_7", 64'(class_vld), 64'hA1);
    do_read(3'd7, 8'hFF, 0);
    do_read(3'd0, 8'b0000_0110, 3);

    // Clear class 5 then read it
    send_cmd(OP_CLEAR, 3'd5);
    model_vld[5] = 1'b0;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_vld", 64'(class_vld), 64'(model_vld));
    do_read(3'd5, 8'hFF, 0);

    // NOP has no effect
    send_cmd(OP_NOP, 3'd0);
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_vld", 64'(class_vld), 64'(model_vld));
    chk("nop_err", 64'(cmd_err), 64'd0);

    // Out-of-range class on the 6-class instance
    e_cmd_valid = 1'b1; e_cmd_op = OP_READ; e_cmd_class = 3'd7;
    step();
    e_cmd_valid = 1'b0;
    chk("err_pulse", 64'(e_cmd_err), 64'd1);
    chk("err_busy", 64'(e_busy), 64'd0);
    chk("err_rd_valid", 64'(e_rd_valid), 64'd0);
    step();
    chk("err_pulse_end", 64'(e_cmd_err), 64'd0);
    chk("err_rd_valid2", 64'(e_rd_valid), 64'd0);
    e_cmd_valid = 1'b1; e_cmd_op = OP_WRITE; e_cmd_class = 3'd6;
    step();
    e_cmd_valid = 1'b0;
    chk("err_wr_pulse", 64'(e_cmd_err), 64'd1);
    chk("err_wr_ready", 64'(e_wr_ready), 64'd0);
    chk("err_wr_vld", 64'(e_class_vld), 64'd0);
    e_cmd_valid = 1'b1; e_cmd_op = OP_READ; e_cmd_class = 3'd5;
    step();
    e_cmd_valid = 1'b0;
    chk("ok6_err", 64'(e_cmd_err), 64'd0);
    chk("ok6_busy", 64'(e_busy), 64'd1);
    chk("ok6_empty", 64'(e_rd_empty), 64'd1);
    step(); step(); step();
    chk("ok6_idle", 64'(e_busy), 64'd0);

    // Partial write of class 2 aborted by reset
    do_write(3'd2, 64'h1111, 64'h2222, 64'h3333, 2, 1'b0);
    chk("partial_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_vld2", 64'(class_vld[2]), 64'd0);
    step(); step();
    rst_n = 1'b1;
    model_vld = '0;
    step();
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_vld_all", 64'(class_vld), 64'd0);
    do_read(3'd0, 8'hFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
